// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory request/response port
// and the decode-side instruction handshake.
interface fetch_unit_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ILEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [ILEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order fetch into an instruction queue,
// redirect with stale-response discard. Optional FETCH_PERF_EN adds perf counters.
module fetch_unit #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     ILEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     IBUF_DEPTH      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);
    localparam int unsigned PTR_W = $clog2(IBUF_DEPTH);
    localparam int unsigned OST_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SUM_W = $clog2(IBUF_DEPTH + MAX_OUTSTANDING + 1);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [OST_W-1:0] outst_q, outst_d;
    logic [OST_W-1:0] drop_q, drop_d;
    logic [PTR_W:0]   wr_q, wr_d, rd_q, rd_d;
    logic [ILEN-1:0]  data_q [IBUF_DEPTH];
    logic [XLEN-1:0]  pcs_q  [IBUF_DEPTH];

    logic [PTR_W:0]   occ_c;
    logic [SUM_W-1:0] credit_c;
    logic             req_valid_c, req_fire_c, rsp_fire_c, push_c, pop_c, discard_c;
    logic             inst_valid_c;

    // Credit: every request in flight already owns a queue slot.
    assign occ_c        = wr_q - rd_q;
    assign credit_c     = SUM_W'(occ_c) + SUM_W'(outst_q);
    assign req_valid_c  = (outst_q < OST_W'(MAX_OUTSTANDING)) &&
                          (credit_c < SUM_W'(IBUF_DEPTH));
    assign req_fire_c   = req_valid_c && bus.imem_req_ready;
    assign rsp_fire_c   = bus.imem_rsp_valid && (outst_q != '0);
    assign inst_valid_c = (occ_c != '0) && !bus.redirect_valid;

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.inst_valid     = inst_valid_c;
    assign bus.inst_data      = data_q[rd_q[PTR_W-1:0]];
    assign bus.inst_pc        = pcs_q[rd_q[PTR_W-1:0]];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        discard_c  = 1'b0;
        outst_d    = outst_q + OST_W'(req_fire_c) - OST_W'(rsp_fire_c);

        if (bus.redirect_valid) begin
            // In-flight requests, including one issued now, come back stale.
            fetch_pc_d = bus.redirect_pc;
            rsp_pc_d   = bus.redirect_pc;
            drop_d     = outst_d;
            wr_d       = '0;
            rd_d       = '0;
            discard_c  = rsp_fire_c;
        end else begin
            if (req_fire_c) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_fire_c) begin
                if (drop_q != '0) begin
                    drop_d    = drop_q - OST_W'(1);
                    discard_c = 1'b1;
                end else begin
                    push_c   = 1'b1;
                    rsp_pc_d = rsp_pc_q + XLEN'(4);
                end
            end
            pop_c = inst_valid_c && bus.inst_ready;
            wr_d  = wr_q + (PTR_W+1)'(push_c);
            rd_d  = rd_q + (PTR_W+1)'(pop_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    // Queue storage needs no reset; validity is carried by the pointers.
    always_ff @(posedge clk) begin
        if (push_c) begin
            data_q[wr_q[PTR_W-1:0]] <= bus.imem_rsp_data;
            pcs_q[wr_q[PTR_W-1:0]]  <= rsp_pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_dropped_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            if (pop_c && (perf_fetched_q != '1)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (discard_c && (perf_dropped_q != '1)) begin
                perf_dropped_q <= perf_dropped_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with an in-order latency-programmable
// instruction memory model (data word = ~address).
module tb_fetch_unit;
    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO = 2;
    localparam logic [31:0] RPC = 32'h0;

    logic clk;
    logic rst_n;
    fetch_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_dropped;
`endif

    fetch_unit #(
        .XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RPC),
        .IBUF_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_dropped(perf_dropped)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model controls
    bit ready_rand = 0;
    bit ready_fixed = 1;
    int lat_min = 1;
    int lat_max = 1;
    bit mem_hold = 0;
    int fires = 0;
    int max_inflight = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    // Memory process: present due response at negedge+1, sample request fire at negedge+2.
    initial begin
        int cyc;
        int last_due;
        int lat;
        int due;
        bit presenting;
        mreq_t e;
        cyc = 0;
        last_due = 0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_req_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                mq.delete();
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
                bus.imem_req_ready = 1'b0;
                fires = 0;
                max_inflight = 0;
                last_due = cyc;
            end else begin
                presenting = 0;
                if (!mem_hold && mq.size() > 0 && mq[0].due <= cyc) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = ~mq[0].addr;
                    void'(mq.pop_front());
                    presenting = 1;
                end else begin
                    bus.imem_rsp_valid = 1'b0;
                    bus.imem_rsp_data  = '0;
                end
                bus.imem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
                #1;
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    lat = $urandom_range(lat_min, lat_max);
                    due = cyc + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    e.addr = bus.imem_req_addr;
                    e.due  = due;
                    mq.push_back(e);
                    fires++;
                    if (mq.size() + int'(presenting) > max_inflight)
                        max_inflight = mq.size() + int'(presenting);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        vectors++;
        if (bus.inst_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid);
        end
        vectors++;
        if (bus.imem_req_addr !== RPC) begin
            miscompares++; $display("FAIL reset_req_addr: got %h want %h", bus.imem_req_addr, RPC);
        end
        vectors++;
        if (bus.imem_req_valid !== 1'b1) begin
            miscompares++; $display("FAIL reset_req_valid: got %b want 1", bus.imem_req_valid);
        end
    endtask

    task automatic test_stream();
        ready_rand = 0; ready_fixed = 1; lat_min = 1; lat_max = 1; mem_hold = 0;
        bus.inst_ready = 1'b1;
        do_reset();
        #3;
        vectors++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL stream_first_req: got v=%b a=%h want v=1 a=00000000",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        @(negedge clk); #3;
        vectors++;
        if (bus.inst_valid !== 1'b0) begin
            miscompares++; $display("FAIL stream_early_valid: got %b want 0", bus.inst_valid);
        end
        @(negedge clk); #3;
        vectors++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_data !== ~32'h0) begin
            miscompares++;
            $display("FAIL stream_first_inst: got v=%b pc=%h d=%h want v=1 pc=00000000 d=ffffffff",
                     bus.inst_valid, bus.inst_pc, bus.inst_data);
        end
        for (int i = 1; i < 8; i++) begin
            @(negedge clk); #3;
            vectors++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * i)) begin
                miscompares++;
                $display("FAIL stream_sustained[%0d]: got v=%b pc=%h want v=1 pc=%h",
                         i, bus.inst_valid, bus.inst_pc, 32'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        int pops;
        ready_rand = 0; ready_fixed = 1; lat_min = 1; lat_max = 1; mem_hold = 0;
        bus.inst_ready = 1'b0;
        do_reset();
        repeat (20) @(negedge clk);
        #3;
        vectors++;
        if (fires !== 4) begin
            miscompares++; $display("FAIL bp_fires: got %0d want 4", fires);
        end
        vectors++;
        if (bus.imem_req_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_req_valid: got %b want 0", bus.imem_req_valid);
        end
        vectors++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=00000000", bus.inst_valid, bus.inst_pc);
        end
        @(negedge clk);
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            vectors++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * i) || bus.inst_data !== ~32'(4 * i)) begin
                miscompares++;
                $display("FAIL bp_drain[%0d]: got v=%b pc=%h d=%h want v=1 pc=%h",
                         i, bus.inst_valid, bus.inst_pc, bus.inst_data, 32'(4 * i));
            end
            @(negedge clk);
        end
        pops = 4;
        for (int c = 0; c < 30 && pops < 8; c++) begin
            #3;
            if (bus.inst_valid && bus.inst_ready) begin
                vectors++;
                if (bus.inst_pc !== 32'(4 * pops)) begin
                    miscompares++;
                    $display("FAIL bp_refill[%0d]: got pc=%h want %h", pops, bus.inst_pc, 32'(4 * pops));
                end
                pops++;
            end
            @(negedge clk);
        end
        vectors++;
        if (pops !== 8) begin
            miscompares++; $display("FAIL bp_refill_timeout: got %0d pops want 8", pops);
        end
    endtask

    task automatic test_redirect_inflight();
        int got;
        bit found;
        logic [31:0] want;
        ready_rand = 0; ready_fixed = 1; lat_min = 1; lat_max = 1; mem_hold = 0;
        bus.inst_ready = 1'b1;
        do_reset();
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk); #3;
            if (bus.imem_req_valid && bus.imem_req_ready && bus.imem_req_addr == 32'h10) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL redir_wait_0x10: got timeout want fire at 00000010");
        end
        mem_hold = 1;
        @(negedge clk);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h100;
        #3;
        vectors++;
        if (bus.imem_req_valid !== 1'b0) begin
            miscompares++; $display("FAIL redir_two_inflight: got req_valid=%b want 0", bus.imem_req_valid);
        end
        vectors++;
        if (bus.inst_valid !== 1'b0) begin
            miscompares++; $display("FAIL redir_inst_valid: got %b want 0", bus.inst_valid);
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        mem_hold = 0;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            #3;
            if (bus.inst_valid && bus.inst_ready) begin
                want = 32'h100 + 32'(4 * got);
                vectors++;
                if (bus.inst_pc !== want || bus.inst_data !== ~want) begin
                    miscompares++;
                    $display("FAIL redir_pc[%0d]: got pc=%h d=%h want pc=%h d=%h",
                             got, bus.inst_pc, bus.inst_data, want, ~want);
                end
                got++;
            end
            @(negedge clk);
        end
        vectors++;
        if (got !== 2) begin
            miscompares++; $display("FAIL redir_timeout: got %0d insts want 2", got);
        end
`ifdef FETCH_PERF_EN
        vectors++;
        if (perf_dropped !== 32'd2) begin
            miscompares++; $display("FAIL redir_perf_dropped: got %0d want 2", perf_dropped);
        end
`endif
    endtask

    task automatic test_redirect_same_cycle();
        int got;
        logic [31:0] want;
        ready_rand = 0; ready_fixed = 1; lat_min = 1; lat_max = 1; mem_hold = 0;
        bus.inst_ready = 1'b1;
        do_reset();
        repeat (5) @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h200;
        #3;
        vectors++;
        if (!(bus.imem_req_valid && bus.imem_req_ready && bus.imem_rsp_valid)) begin
            miscompares++;
            $display("FAIL same_cyc_fires: got req=%b rdy=%b rsp=%b want 1 1 1",
                     bus.imem_req_valid, bus.imem_req_ready, bus.imem_rsp_valid);
        end
        vectors++;
        if (bus.inst_valid !== 1'b0) begin
            miscompares++; $display("FAIL same_cyc_inst_valid: got %b want 0", bus.inst_valid);
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #3;
        vectors++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin
            miscompares++;
            $display("FAIL same_cyc_new_req: got v=%b a=%h want v=1 a=00000200",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        @(negedge clk);
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            #3;
            if (bus.inst_valid && bus.inst_ready) begin
                want = 32'h200 + 32'(4 * got);
                vectors++;
                if (bus.inst_pc !== want || bus.inst_data !== ~want) begin
                    miscompares++;
                    $display("FAIL same_cyc_pc[%0d]: got pc=%h d=%h want pc=%h", got, bus.inst_pc, bus.inst_data, want);
                end
                got++;
            end
            @(negedge clk);
        end
        vectors++;
        if (got !== 2) begin
            miscompares++; $display("FAIL same_cyc_timeout: got %0d insts want 2", got);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_pc;
        bit prev_stall;
        int pops;
        ready_rand = 1; lat_min = 1; lat_max = 3; mem_hold = 0;
        bus.inst_ready = 1'b1;
        do_reset();
        exp_pc = 32'h0;
        prev_stall = 0;
        prev_pc = '0;
        pops = 0;
        for (int c = 0; c < 400; c++) begin
            bus.inst_ready = 1'($urandom_range(0, 1));
            #3;
            if (prev_stall) begin
                vectors++;
                if (bus.inst_valid !== 1'b1 || bus.inst_pc !== prev_pc) begin
                    miscompares++;
                    $display("FAIL rand_stable: got v=%b pc=%h want v=1 pc=%h", bus.inst_valid, bus.inst_pc, prev_pc);
                end
            end
            if (bus.inst_valid && bus.inst_ready) begin
                vectors++;
                if (bus.inst_pc !== exp_pc || bus.inst_data !== ~exp_pc) begin
                    miscompares++;
                    $display("FAIL rand_seq: got pc=%h d=%h want pc=%h d=%h", bus.inst_pc, bus.inst_data, exp_pc, ~exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            prev_stall = bus.inst_valid && !bus.inst_ready;
            prev_pc = bus.inst_pc;
            @(negedge clk);
        end
        vectors++;
        if (max_inflight > int'(MAXO)) begin
            miscompares++; $display("FAIL rand_inflight: got %0d want <= %0d", max_inflight, MAXO);
        end
        vectors++;
        if (pops < 40) begin
            miscompares++; $display("FAIL rand_progress: got %0d pops want >= 40", pops);
        end
        ready_rand = 0;
    endtask

    task automatic test_reset_midstream();
        int got;
        ready_rand = 0; ready_fixed = 1; lat_min = 1; lat_max = 1; mem_hold = 0;
        bus.inst_ready = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        #3;
        vectors++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_pre: got v=%b pc=%h want v=1 pc=00000000", bus.inst_valid, bus.inst_pc);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        vectors++;
        if (bus.inst_valid !== 1'b0) begin
            miscompares++; $display("FAIL mid_inst_valid: got %b want 0", bus.inst_valid);
        end
        vectors++;
        if (bus.imem_req_addr !== RPC) begin
            miscompares++; $display("FAIL mid_req_addr: got %h want %h", bus.imem_req_addr, RPC);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.inst_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            #3;
            if (bus.inst_valid && bus.inst_ready) begin
                vectors++;
                if (bus.inst_pc !== RPC + 32'(4 * got)) begin
                    miscompares++;
                    $display("FAIL mid_restart[%0d]: got pc=%h want %h", got, bus.inst_pc, RPC + 32'(4 * got));
                end
                got++;
            end
            @(negedge clk);
        end
        vectors++;
        if (got !== 2) begin
            miscompares++; $display("FAIL mid_restart_timeout: got %0d insts want 2", got);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
